// File: rtl/seq_divider32.sv
// seq_divider32: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Remainder goes to HI and quotient goes to LO.
// A start/busy/done handshake lets the pipeline stall while a division runs.
module seq_divider32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [CntW-1:0]  r_cnt;
  // The restored remainder is always below the divisor, so WIDTH bits hold it.
  // The shifted value and the trial difference need WIDTH+1 bits.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs_mag;
  logic [WIDTH-1:0] r_dvd_raw;
  logic             r_dvd_neg;
  logic             r_dvs_neg;
  logic             r_dbz;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Operand magnitudes, result sign fixups and the trial subtraction a + ~b + 1.
  always_comb begin
    w_dvd_mag = (i_is_signed && i_dividend[WIDTH-1]) ? (~i_dividend + WIDTH'(1)) : i_dividend;
    w_dvs_mag = (i_is_signed && i_divisor[WIDTH-1])  ? (~i_divisor + WIDTH'(1))  : i_divisor;
    w_shift   = {r_rem, r_quo[WIDTH-1]};
    w_trial   = w_shift + ~{1'b0, r_dvs_mag} + (WIDTH + 1)'(1);
    w_quo_fix = (r_dvd_neg ^ r_dvs_neg) ? (~r_quo + WIDTH'(1)) : r_quo;
    w_rem_fix = r_dvd_neg ? (~r_rem + WIDTH'(1)) : r_rem;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a zero divisor skips straight to FIX.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = (i_divisor == '0) ? StFix : StCalc;
        end
      end
      StCalc: begin
        if (r_cnt == CntLast) begin
          w_state_next = StFix;
        end
      end
      StFix:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Operand capture, one shift/subtract per CALC edge, result write-back in FIX.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs_mag     <= '0;
      r_dvd_raw     <= '0;
      r_dvd_neg     <= 1'b0;
      r_dvs_neg     <= 1'b0;
      r_dbz         <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_dvd_mag;
            r_dvs_mag <= w_dvs_mag;
            r_dvd_raw <= i_dividend;
            r_dvd_neg <= i_is_signed & i_dividend[WIDTH-1];
            r_dvs_neg <= i_is_signed & i_divisor[WIDTH-1];
            r_dbz     <= (i_divisor == '0);
          end
        end
        StCalc: begin
          // A clear top bit of the trial means the subtraction did not borrow.
          r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
          r_cnt <= r_cnt + CntW'(1);
        end
        StFix: begin
          r_done <= 1'b1;
          if (r_dbz) begin
            r_quotient    <= '1;
            r_remainder   <= r_dvd_raw;
            r_div_by_zero <= 1'b1;
          end else begin
            r_quotient    <= w_quo_fix;
            r_remainder   <= w_rem_fix;
            r_div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != StIdle);
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule
